// File: rtl/maze_env_if.sv
// ============================================================================
// maze_env_if
// Agent <-> maze environment step interface.
//   action_valid/action_ready/action : one action per step, agent -> env
//   step_valid/step_ready            : step result handshake, env -> agent
//   current_st, next_st, reward      : position, produced state, Q8.8 reward
//   fail, finish, timeout            : terminal flags, valid with step_valid
//   new_gen                          : one-cycle pulse at episode start
//   episode, step_count              : completed episodes, steps this episode
// Modports: master = agent side, slave = environment side.
// ============================================================================
interface maze_env_if;
    logic        action_valid;
    logic        action_ready;
    logic [3:0]  action;
    logic        step_valid;
    logic        step_ready;
    logic [5:0]  current_st;
    logic [5:0]  next_st;
    logic [15:0] reward;
    logic        fail;
    logic        finish;
    logic        timeout;
    logic        new_gen;
    logic [9:0]  episode;
    logic [7:0]  step_count;

    modport master (
        output action_valid, action, step_ready,
        input  action_ready, step_valid, current_st, next_st, reward,
               fail, finish, timeout, new_gen, episode, step_count
    );

    modport slave (
        input  action_valid, action, step_ready,
        output action_ready, step_valid, current_st, next_st, reward,
               fail, finish, timeout, new_gen, episode, step_count
    );
endinterface

// File: rtl/maze_env.sv
// ============================================================================
// maze_env
// Environment side of an agent/maze step interface on a 5x5 grid (states
// 1..25, row-major). Takes one action per step, moves the agent, returns the
// next state, a signed Q8.8 reward and terminal flags, and restarts episodes
// by itself.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous reset, active low
//   bus    : maze_env_if.slave (action handshake in, step result out)
// ============================================================================
module maze_env #(
    parameter logic [5:0]         START_ST  = 6'd1,
    parameter logic [5:0]         GOAL_ST   = 6'd25,
    parameter logic [24:0]        WALL_MASK = 25'h0010140,
    parameter logic [7:0]         MAX_STEPS = 8'd64,
    parameter logic signed [15:0] R_STEP    = 16'hFF00,
    parameter logic signed [15:0] R_BUMP    = 16'hFE00,
    parameter logic signed [15:0] R_WALL    = 16'hF600,
    parameter logic signed [15:0] R_GOAL    = 16'h0A00
) (
    input  logic       clk,
    input  logic       rst_n,
    maze_env_if.slave  bus
);

    localparam logic [1:0] S_RST_EP = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_EVAL   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    // ------------------------------------------------------------------
    // Grid helpers: row/column of a zero-based cell index (0..24)
    // ------------------------------------------------------------------
    function automatic logic [2:0] row_of(input logic [4:0] idx);
        if (idx < 5'd5)       return 3'd0;
        else if (idx < 5'd10) return 3'd1;
        else if (idx < 5'd15) return 3'd2;
        else if (idx < 5'd20) return 3'd3;
        else                  return 3'd4;
    endfunction

    function automatic logic [2:0] col_of(input logic [4:0] idx, input logic [2:0] row);
        logic [4:0] t;
        t = idx - (5'(row) * 5'd5);
        return t[2:0];
    endfunction

    // Reward selection follows the move-rule priority: bump, wall, goal, step.
    function automatic logic signed [15:0] sel_reward(input logic bump,
                                                      input logic wall,
                                                      input logic goal);
        if (bump)      return R_BUMP;
        else if (wall) return R_WALL;
        else if (goal) return R_GOAL;
        else           return R_STEP;
    endfunction

    logic [1:0]         r_state;
    logic [5:0]         r_cur;
    logic [5:0]         r_next;
    logic signed [15:0] r_reward;
    logic               r_fail;
    logic               r_finish;
    logic               r_timeout;
    logic               r_new_gen;
    logic [9:0]         r_episode;
    logic [7:0]         r_step_cnt;
    logic [3:0]         r_act;

    logic [4:0]         w_cur_idx;
    logic [2:0]         w_row;
    logic [2:0]         w_col;
    logic [5:0]         w_tgt;
    logic [4:0]         w_tgt_idx;
    logic               w_bump;
    logic               w_wall;
    logic               w_goal;
    logic               w_last;
    logic               w_timeout;
    logic               w_fail;
    logic signed [15:0] w_reward;

    // ------------------------------------------------------------------
    // Move evaluation (consumed in EVAL from r_cur and the latched action)
    // ------------------------------------------------------------------
    assign w_cur_idx = 5'(r_cur - 6'd1);
    assign w_row     = row_of(w_cur_idx);
    assign w_col     = col_of(w_cur_idx, w_row);

    always_comb begin
        w_bump = 1'b0;
        w_tgt  = r_cur;
        case (r_act)
            4'd0: if (w_row != 3'd0) w_tgt = r_cur - 6'd5; else w_bump = 1'b1;
            4'd1: if (w_row != 3'd4) w_tgt = r_cur + 6'd5; else w_bump = 1'b1;
            4'd2: if (w_col != 3'd0) w_tgt = r_cur - 6'd1; else w_bump = 1'b1;
            4'd3: if (w_col != 3'd4) w_tgt = r_cur + 6'd1; else w_bump = 1'b1;
            default: w_bump = 1'b1;
        endcase
    end

    assign w_tgt_idx = 5'(w_tgt - 6'd1);
    assign w_wall    = !w_bump && WALL_MASK[w_tgt_idx];
    assign w_goal    = !w_bump && !w_wall && (w_tgt == GOAL_ST);
    // Timeout only applies when this step would not already end the episode.
    assign w_last    = (({1'b0, r_step_cnt} + 9'd1) == {1'b0, MAX_STEPS});
    assign w_timeout = w_last && !w_wall && !w_goal;
    assign w_fail    = w_wall || w_timeout;
    assign w_reward  = sel_reward(w_bump, w_wall, w_goal);

    // ------------------------------------------------------------------
    // Control FSM and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_RST_EP;
            r_cur      <= 6'd0;
            r_next     <= 6'd0;
            r_reward   <= 16'sd0;
            r_fail     <= 1'b0;
            r_finish   <= 1'b0;
            r_timeout  <= 1'b0;
            r_new_gen  <= 1'b0;
            r_episode  <= 10'd0;
            r_step_cnt <= 8'd0;
            r_act      <= 4'd0;
        end else begin
            r_new_gen <= 1'b0;
            case (r_state)
                S_RST_EP: begin
                    r_cur      <= START_ST;
                    r_step_cnt <= 8'd0;
                    r_new_gen  <= 1'b1;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.action_valid) begin
                        r_act   <= bus.action;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_next    <= w_bump ? r_cur : w_tgt;
                    r_reward  <= w_reward;
                    r_fail    <= w_fail;
                    r_finish  <= w_goal;
                    r_timeout <= w_timeout;
                    r_state   <= S_RESP;
                end
                default: begin
                    // Results stay frozen until the agent takes them.
                    if (bus.step_ready) begin
                        if (!r_fail) r_cur <= r_next;
                        r_step_cnt <= r_step_cnt + 8'd1;
                        r_fail     <= 1'b0;
                        r_finish   <= 1'b0;
                        r_timeout  <= 1'b0;
                        if (r_fail || r_finish) begin
                            r_episode <= r_episode + 10'd1;
                            r_state   <= S_RST_EP;
                        end else begin
                            r_state   <= S_WAIT;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.action_ready = (r_state == S_WAIT);
    assign bus.step_valid   = (r_state == S_RESP);
    assign bus.current_st   = r_cur;
    assign bus.next_st      = r_next;
    assign bus.reward       = r_reward;
    assign bus.fail         = r_fail;
    assign bus.finish       = r_finish;
    assign bus.timeout      = r_timeout;
    assign bus.new_gen      = r_new_gen;
    assign bus.episode      = r_episode;
    assign bus.step_count   = r_step_cnt;

endmodule

// File: tb/tb_maze_env.sv
// Directed bench for maze_env: instance A uses default parameters,
// instance B uses MAX_STEPS=4 for the timeout scenarios.
module tb_maze_env;
    logic clk;
    logic rst_n_a;
    logic rst_n_b;
    int   n_chk;
    int   n_err;

    maze_env_if bus_a ();
    maze_env_if bus_b ();

    maze_env u_dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a.slave)
    );

    maze_env #(.MAX_STEPS(8'd4)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ar;
        logic        sv;
        logic        fail;
        logic        finish;
        logic        tmo;
        logic        ng;
        logic [5:0]  cur;
        logic [5:0]  nxt;
        logic [15:0] rew;
        logic [9:0]  ep;
        logic [7:0]  sc;
    } snap_t;

    function automatic snap_t rd(input bit sel);
        snap_t s;
        if (sel) begin
            s.ar = bus_b.action_ready; s.sv = bus_b.step_valid;
            s.fail = bus_b.fail; s.finish = bus_b.finish; s.tmo = bus_b.timeout;
            s.ng = bus_b.new_gen; s.cur = bus_b.current_st; s.nxt = bus_b.next_st;
            s.rew = bus_b.reward; s.ep = bus_b.episode; s.sc = bus_b.step_count;
        end else begin
            s.ar = bus_a.action_ready; s.sv = bus_a.step_valid;
            s.fail = bus_a.fail; s.finish = bus_a.finish; s.tmo = bus_a.timeout;
            s.ng = bus_a.new_gen; s.cur = bus_a.current_st; s.nxt = bus_a.next_st;
            s.rew = bus_a.reward; s.ep = bus_a.episode; s.sc = bus_a.step_count;
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for action_ready, present one action, and check the
    // two-edge latency to step_valid.
    task automatic issue(input bit sel, input logic [3:0] act);
        snap_t s;
        int n;
        n = 0;
        s = rd(sel);
        while (s.ar !== 1'b1 && n < 16) begin
            tick();
            s = rd(sel);
            n++;
        end
        check("ready_wait", {31'd0, s.ar}, 32'd1);
        if (sel) begin bus_b.action_valid = 1'b1; bus_b.action = act; end
        else     begin bus_a.action_valid = 1'b1; bus_a.action = act; end
        tick();
        if (sel) bus_b.action_valid = 1'b0; else bus_a.action_valid = 1'b0;
        s = rd(sel);
        check("sv_eval_low", {31'd0, s.sv}, 32'd0);
        tick();
        s = rd(sel);
        check("sv_resp_high", {31'd0, s.sv}, 32'd1);
    endtask

    task automatic ack(input bit sel);
        if (sel) bus_b.step_ready = 1'b1; else bus_a.step_ready = 1'b1;
        tick();
        if (sel) bus_b.step_ready = 1'b0; else bus_a.step_ready = 1'b0;
    endtask

    task automatic expect_res(input bit sel, input string tag, input logic [5:0] nxt,
                              input logic [15:0] rew, input logic fl, input logic fin,
                              input logic tmo);
        snap_t s;
        s = rd(sel);
        check({tag, "_next"},    {26'd0, s.nxt}, {26'd0, nxt});
        check({tag, "_reward"},  {16'd0, s.rew}, {16'd0, rew});
        check({tag, "_fail"},    {31'd0, s.fail}, {31'd0, fl});
        check({tag, "_finish"},  {31'd0, s.finish}, {31'd0, fin});
        check({tag, "_timeout"}, {31'd0, s.tmo}, {31'd0, tmo});
    endtask

    // After a terminal ack: one RST_EP cycle, then new_gen with the start state.
    task automatic expect_restart(input bit sel, input string tag, input logic [9:0] ep);
        snap_t s;
        s = rd(sel);
        check({tag, "_ng_rst_ep"}, {31'd0, s.ng}, 32'd0);
        check({tag, "_episode"}, {22'd0, s.ep}, {22'd0, ep});
        tick();
        s = rd(sel);
        check({tag, "_new_gen"}, {31'd0, s.ng}, 32'd1);
        check({tag, "_cur_start"}, {26'd0, s.cur}, 32'd1);
        check({tag, "_sc_zero"}, {24'd0, s.sc}, 32'd0);
    endtask

    initial begin
        snap_t s;
        n_chk = 0;
        n_err = 0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        bus_a.action_valid = 1'b0; bus_a.action = 4'd0; bus_a.step_ready = 1'b0;
        bus_b.action_valid = 1'b0; bus_b.action = 4'd0; bus_b.step_ready = 1'b0;

        // Reset held for two edges
        tick();
        tick();
        s = rd(1'b0);
        check("rst_cur", {26'd0, s.cur}, 32'd0);
        check("rst_ready", {31'd0, s.ar}, 32'd0);
        check("rst_new_gen", {31'd0, s.ng}, 32'd0);
        check("rst_valid", {31'd0, s.sv}, 32'd0);
        check("rst_reward", {16'd0, s.rew}, 32'd0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        tick();
        s = rd(1'b0);
        check("rel_new_gen", {31'd0, s.ng}, 32'd1);
        check("rel_cur", {26'd0, s.cur}, 32'd1);
        check("rel_episode", {22'd0, s.ep}, 32'd0);
        check("rel_ready", {31'd0, s.ar}, 32'd1);
        tick();
        s = rd(1'b0);
        check("new_gen_one_cycle", {31'd0, s.ng}, 32'd0);

        // Legal move right, then bump up on the top row
        issue(1'b0, 4'd3);
        expect_res(1'b0, "right1", 6'd2, 16'hFF00, 1'b0, 1'b0, 1'b0);
        ack(1'b0);
        s = rd(1'b0);
        check("right1_cur", {26'd0, s.cur}, 32'd2);
        check("right1_sc", {24'd0, s.sc}, 32'd1);
        issue(1'b0, 4'd0);
        expect_res(1'b0, "up_bump", 6'd2, 16'hFE00, 1'b0, 1'b0, 1'b0);
        ack(1'b0);

        // Down from 2 into wall 7
        issue(1'b0, 4'd1);
        expect_res(1'b0, "wall7", 6'd7, 16'hF600, 1'b1, 1'b0, 1'b0);
        ack(1'b0);
        s = rd(1'b0);
        check("wall7_cur_kept", {26'd0, s.cur}, 32'd2);
        expect_restart(1'b0, "ep1", 10'd1);

        // Path to goal along top row and right column, with an edge bump at 5
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 4'd3);
            expect_res(1'b0, "row_right", 6'(2 + i), 16'hFF00, 1'b0, 1'b0, 1'b0);
            ack(1'b0);
        end
        issue(1'b0, 4'd3);
        expect_res(1'b0, "right_edge", 6'd5, 16'hFE00, 1'b0, 1'b0, 1'b0);
        ack(1'b0);
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, 4'd1);
            expect_res(1'b0, "col_down", 6'(10 + 5 * i), 16'hFF00, 1'b0, 1'b0, 1'b0);
            ack(1'b0);
        end
        issue(1'b0, 4'd1);
        expect_res(1'b0, "goal", 6'd25, 16'h0A00, 1'b0, 1'b1, 1'b0);
        ack(1'b0);
        expect_restart(1'b0, "ep2", 10'd2);

        // step_ready withheld: results frozen, no second accept
        issue(1'b0, 4'd1);
        bus_a.action_valid = 1'b1;
        bus_a.action = 4'd3;
        for (int i = 0; i < 3; i++) begin
            expect_res(1'b0, "hold", 6'd6, 16'hFF00, 1'b0, 1'b0, 1'b0);
            s = rd(1'b0);
            check("hold_ready", {31'd0, s.ar}, 32'd0);
            check("hold_valid", {31'd0, s.sv}, 32'd1);
            tick();
        end
        bus_a.action_valid = 1'b0;
        ack(1'b0);
        s = rd(1'b0);
        check("after_hold_ready", {31'd0, s.ar}, 32'd1);
        check("after_hold_cur", {26'd0, s.cur}, 32'd6);
        check("after_hold_sc", {24'd0, s.sc}, 32'd1);
        issue(1'b0, 4'd15);
        expect_res(1'b0, "illegal15", 6'd6, 16'hFE00, 1'b0, 1'b0, 1'b0);
        ack(1'b0);

        // Instance B: timeout after four illegal actions
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, 4'd9);
            expect_res(1'b1, "b_ill", 6'd1, 16'hFE00, 1'b0, 1'b0, 1'b0);
            ack(1'b1);
        end
        s = rd(1'b1);
        check("b_sc3", {24'd0, s.sc}, 32'd3);
        issue(1'b1, 4'd9);
        expect_res(1'b1, "b_timeout", 6'd1, 16'hFE00, 1'b1, 1'b0, 1'b1);
        ack(1'b1);
        expect_restart(1'b1, "b_ep1", 10'd1);

        // Wall on the MAX_STEPS-th step: fail without timeout
        issue(1'b1, 4'd3); ack(1'b1);
        issue(1'b1, 4'd3); ack(1'b1);
        issue(1'b1, 4'd2);
        expect_res(1'b1, "b_left", 6'd2, 16'hFF00, 1'b0, 1'b0, 1'b0);
        ack(1'b1);
        issue(1'b1, 4'd1);
        expect_res(1'b1, "b_wall_last", 6'd7, 16'hF600, 1'b1, 1'b0, 1'b0);
        ack(1'b1);
        expect_restart(1'b1, "b_ep2", 10'd2);

        // Reset asserted while in RESP
        issue(1'b1, 4'd3);
        expect_res(1'b1, "b_pre_rst", 6'd2, 16'hFF00, 1'b0, 1'b0, 1'b0);
        rst_n_b = 1'b0;
        tick();
        s = rd(1'b1);
        check("b_rst_valid", {31'd0, s.sv}, 32'd0);
        check("b_rst_next", {26'd0, s.nxt}, 32'd0);
        check("b_rst_reward", {16'd0, s.rew}, 32'd0);
        check("b_rst_cur", {26'd0, s.cur}, 32'd0);
        check("b_rst_episode", {22'd0, s.ep}, 32'd0);
        check("b_rst_sc", {24'd0, s.sc}, 32'd0);
        check("b_rst_ready", {31'd0, s.ar}, 32'd0);
        rst_n_b = 1'b1;
        tick();
        s = rd(1'b1);
        check("b_rel_new_gen", {31'd0, s.ng}, 32'd1);
        check("b_rel_cur", {26'd0, s.cur}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
